// File: rtl/rca_reconfig_scheduler.sv
// Test-sweep scheduler for the reconfigurable ripple-carry adder: steps 8 LUT patterns,
// accumulates per-cell fault flags and publishes a spare-cell map. Optional macro: PERIODIC_RETEST_EN.
module rca_reconfig_scheduler #(
    parameter int SETTLE          = 2,
    parameter int RETEST_INTERVAL = 1024
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       start,
    input  logic [3:0] sf,
    input  logic [3:0] cf,
    output logic [2:0] lut_o,
    output logic       test_en,
    output logic [3:0] cfg_sf,
    output logic [3:0] cfg_cf,
    output logic       cfg_valid,
    output logic       done,
    output logic       uncorrectable
);

    // state   | meaning
    // IDLE    | waiting for start (or retest timer expiry)
    // APPLY   | pattern index on lut_o, settle down-counter running
    // SAMPLE  | fault flags ORed into the accumulators
    // EVAL    | faulty-cell count compared against the single spare
    // PUBLISH | cfg maps loaded when correctable, done raised
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        APPLY   = 3'd1,
        SAMPLE  = 3'd2,
        EVAL    = 3'd3,
        PUBLISH = 3'd4
    } state_t;

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE - 1);

    state_t     state;
    state_t     state_nxt;
    logic [2:0] idx;
    logic [3:0] settle_cnt;
    logic [3:0] acc_sf;
    logic [3:0] acc_cf;
    logic [3:0] faulty;
    logic       sweep_go;
    logic       settle_tc;
    logic       last_pat;
    logic       retest_tc;

    assign settle_tc = (settle_cnt == 4'd0);
    assign last_pat  = (idx == 3'd7);
    assign faulty    = acc_sf | acc_cf;
    assign lut_o     = idx;

`ifdef PERIODIC_RETEST_EN
    localparam logic [15:0] RETEST_LD = 16'(RETEST_INTERVAL - 1);

    logic [15:0] retest_cnt;

    // Loaded as done rises, so the IDLE cycle that sees zero is the RETEST_INTERVAL-th idle cycle.
    assign retest_tc = done && (retest_cnt == 16'd0);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            retest_cnt <= 16'd0;
        end else if (sweep_go || state == PUBLISH) begin
            retest_cnt <= RETEST_LD;
        end else if (state == IDLE && done && retest_cnt != 16'd0) begin
            retest_cnt <= retest_cnt - 16'd1;
        end
    end
`else
    assign retest_tc = 1'b0;
`endif

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sweep_go  = 1'b0;
        test_en   = 1'b0;
        case (state)
            IDLE: begin
                if (start || retest_tc) begin
                    sweep_go  = 1'b1;
                    state_nxt = APPLY;
                end
            end
            APPLY: begin
                test_en = 1'b1;
                if (settle_tc) begin
                    state_nxt = SAMPLE;
                end
            end
            SAMPLE: begin
                test_en   = 1'b1;
                state_nxt = last_pat ? EVAL : APPLY;
            end
            EVAL:    state_nxt = PUBLISH;
            PUBLISH: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            idx           <= 3'd0;
            settle_cnt    <= 4'd0;
            acc_sf        <= 4'd0;
            acc_cf        <= 4'd0;
            cfg_sf        <= 4'd0;
            cfg_cf        <= 4'd0;
            cfg_valid     <= 1'b0;
            done          <= 1'b0;
            uncorrectable <= 1'b0;
        end else begin
            cfg_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (sweep_go) begin
                        idx           <= 3'd0;
                        settle_cnt    <= SETTLE_LD;
                        acc_sf        <= 4'd0;
                        acc_cf        <= 4'd0;
                        done          <= 1'b0;
                        uncorrectable <= 1'b0;
                    end
                end
                APPLY: begin
                    if (!settle_tc) begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                SAMPLE: begin
                    acc_sf <= acc_sf | sf;
                    acc_cf <= acc_cf | cf;
                    if (!last_pat) begin
                        idx        <= idx + 3'd1;
                        settle_cnt <= SETTLE_LD;
                    end
                end
                EVAL: begin
                    // more than one bit set: clearing the lowest set bit leaves something
                    uncorrectable <= |(faulty & (faulty - 4'd1));
                end
                PUBLISH: begin
                    done <= 1'b1;
                    if (!uncorrectable) begin
                        cfg_sf    <= acc_sf;
                        cfg_cf    <= acc_cf;
                        cfg_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rca_reconfig_scheduler.sv
// Self-checking bench for rca_reconfig_scheduler: timeline model compared every cycle,
// plus directed sweeps with literal expectations. Honours PERIODIC_RETEST_EN.
module tb_rca_reconfig_scheduler;
    localparam int S   = 2;
    localparam int RI  = 16;
    localparam int PER = S + 1;
    localparam int NP  = 8;

    logic       clk   = 1'b0;
    logic       clr_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] sf    = 4'd0;
    logic [3:0] cf    = 4'd0;
    logic [2:0] lut_o;
    logic       test_en;
    logic [3:0] cfg_sf;
    logic [3:0] cfg_cf;
    logic       cfg_valid;
    logic       done;
    logic       uncorrectable;

    int n_checks = 0;
    int n_err    = 0;

    rca_reconfig_scheduler #(.SETTLE(S), .RETEST_INTERVAL(RI)) dut (
        .clk(clk), .clr_n(clr_n), .start(start), .sf(sf), .cf(cf),
        .lut_o(lut_o), .test_en(test_en), .cfg_sf(cfg_sf), .cfg_cf(cfg_cf),
        .cfg_valid(cfg_valid), .done(done), .uncorrectable(uncorrectable)
    );

    always #5 clk = ~clk;

    // Model: a sweep is a timeline of offsets k from the start edge.
    logic [2:0] m_lut  = 3'd0;
    logic       m_ten  = 1'b0;
    logic [3:0] m_csf  = 4'd0;
    logic [3:0] m_ccf  = 4'd0;
    logic       m_val  = 1'b0;
    logic       m_done = 1'b0;
    logic       m_unc  = 1'b0;
    logic [3:0] m_asf  = 4'd0;
    logic [3:0] m_acf  = 4'd0;
    logic       m_busy = 1'b0;
    logic       m_trig = 1'b0;
    int         m_k    = 0;
    int         m_idle = 0;

    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            m_lut = 3'd0; m_ten = 1'b0; m_csf = 4'd0; m_ccf = 4'd0; m_val = 1'b0;
            m_done = 1'b0; m_unc = 1'b0; m_asf = 4'd0; m_acf = 4'd0;
            m_busy = 1'b0; m_k = 0; m_idle = 0;
        end else begin
            m_val = 1'b0;
            if (m_busy) begin
                if (m_k < NP * PER && (m_k % PER) == PER - 1) begin
                    m_asf = m_asf | sf;
                    m_acf = m_acf | cf;
                end
                m_k = m_k + 1;
                if (m_k < NP * PER) begin
                    m_lut = 3'(m_k / PER);
                    m_ten = 1'b1;
                end else begin
                    m_ten = 1'b0;
                end
                if (m_k == NP * PER + 1) m_unc = ($countones(m_asf | m_acf) > 1);
                if (m_k == NP * PER + 2) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    m_idle = 0;
                    if (!m_unc) begin
                        m_csf = m_asf;
                        m_ccf = m_acf;
                        m_val = 1'b1;
                    end
                end
            end else begin
                m_trig = start;
`ifdef PERIODIC_RETEST_EN
                if (m_done) begin
                    m_idle = m_idle + 1;
                    if (m_idle >= RI) m_trig = 1'b1;
                end
`endif
                if (m_trig) begin
                    m_busy = 1'b1; m_k = 0; m_lut = 3'd0; m_ten = 1'b1;
                    m_asf = 4'd0; m_acf = 4'd0; m_done = 1'b0; m_unc = 1'b0; m_idle = 0;
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("lut_o", int'(lut_o), int'(m_lut));
        chk("test_en", int'(test_en), int'(m_ten));
        chk("cfg_sf", int'(cfg_sf), int'(m_csf));
        chk("cfg_cf", int'(cfg_cf), int'(m_ccf));
        chk("cfg_valid", int'(cfg_valid), int'(m_val));
        chk("done", int'(done), int'(m_done));
        chk("uncorrectable", int'(uncorrectable), int'(m_unc));
    end

    // Faults land only on the SAMPLE cycle of patterns pa/pb; junk drives every other cycle.
    task automatic sweep(input int pa, input logic [3:0] sfa, input logic [3:0] cfa,
                         input int pb, input logic [3:0] sfb, input logic [3:0] cfb,
                         input logic [3:0] junk, input logic keep_start, output int lat);
        lat = -1;
        @(negedge clk); start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = keep_start;
        for (int k = 0; k < 60; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            if (k < NP * PER && (k % PER) == PER - 1) begin
                sf = 4'd0; cf = 4'd0;
                if (k / PER == pa) begin sf = sfa; cf = cfa; end
                if (k / PER == pb) begin sf = sf | sfb; cf = cf | cfb; end
            end else begin
                sf = junk; cf = junk;
            end
            @(negedge clk);
        end
        sf = 4'd0; cf = 4'd0;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 0; k < 60; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int lat;
        repeat (2) @(negedge clk);
        chk("rst_lut", int'(lut_o), 0);
        chk("rst_test_en", int'(test_en), 0);
        chk("rst_cfg", int'({cfg_sf, cfg_cf}), 0);
        chk("rst_flags", int'({cfg_valid, done, uncorrectable}), 0);
        #2 clr_n = 1'b1;

        // zero faults: correctable, maps 0000
        sweep(-1, 4'd0, 4'd0, -1, 4'd0, 4'd0, 4'd0, 1'b0, lat);
        chk("t1_latency", lat, 26);
        chk("t1_valid", int'(cfg_valid), 1);
        chk("t1_cfg", int'({cfg_sf, cfg_cf}), 0);
        chk("t1_unc", int'(uncorrectable), 0);

        // single sum fault on pattern 5, noise everywhere else
        sweep(5, 4'b0100, 4'd0, -1, 4'd0, 4'd0, 4'b1111, 1'b0, lat);
        chk("t2_latency", lat, 26);
        chk("t2_cfg_sf", int'(cfg_sf), 4);
        chk("t2_cfg_cf", int'(cfg_cf), 0);
        chk("t2_unc", int'(uncorrectable), 0);
        chk("t2_valid", int'(cfg_valid), 1);

        // prior map 0010, then two faulty cells -> uncorrectable, map held
        sweep(0, 4'b0010, 4'd0, -1, 4'd0, 4'd0, 4'd0, 1'b0, lat);
        chk("t3a_cfg_sf", int'(cfg_sf), 2);
        sweep(1, 4'b0001, 4'd0, 6, 4'd0, 4'b1000, 4'd0, 1'b0, lat);
        chk("t3_latency", lat, 26);
        chk("t3_unc", int'(uncorrectable), 1);
        chk("t3_valid", int'(cfg_valid), 0);
        chk("t3_cfg_sf", int'(cfg_sf), 2);
        chk("t3_cfg_cf", int'(cfg_cf), 0);
        chk("t3_done", int'(done), 1);

        // reset during pattern 4
        @(negedge clk); start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        repeat (4 * PER + 1) @(negedge clk);
        chk("t4_lut_before", int'(lut_o), 4);
        #2 clr_n = 1'b0;
        #1;
        chk("t4_lut", int'(lut_o), 0);
        chk("t4_test_en", int'(test_en), 0);
        chk("t4_cfg", int'({cfg_sf, cfg_cf}), 0);
        chk("t4_flags", int'({cfg_valid, done, uncorrectable}), 0);
        @(negedge clk); #2 clr_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("t4_idle_test_en", int'(test_en), 0);
        chk("t4_idle_done", int'(done), 0);

        // start held high: one sweep, then exactly one new sweep after the IDLE cycle
        sweep(-1, 4'd0, 4'd0, -1, 4'd0, 4'd0, 4'd0, 1'b1, lat);
        chk("t5_latency", lat, 26);
        @(negedge clk);
        chk("t5_restart_test_en", int'(test_en), 1);
        chk("t5_restart_lut", int'(lut_o), 0);
        chk("t5_restart_done", int'(done), 0);
        start = 1'b0;
        wait_done(lat);
        chk("t5_second_latency", lat, 26);

`ifdef PERIODIC_RETEST_EN
        lat = -1;
        for (int j = 0; j < 40; j++) begin
            if (test_en) begin
                lat = j;
                break;
            end
            @(negedge clk);
        end
        chk("retest_delay", lat, 16);
        wait_done(lat);
        chk("retest_latency", lat, 26);
`else
        repeat (40) @(negedge clk);
        chk("no_retest_test_en", int'(test_en), 0);
        chk("no_retest_done", int'(done), 1);
`endif

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/rca_reconfig_scheduler.md
RCA_RECONFIG_SCHEDULER -- requirements
Module: rca_reconfig_scheduler

Interface
REQ-001 SHALL have parameter SETTLE, default 2, meaning cycles lut_o is held before fault flags are sampled; legal range 1..15.
REQ-002 SHALL have parameter RETEST_INTERVAL, default 1024, meaning idle cycles between automatic sweeps; legal range 16..65535.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port clr_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  request one test sweep, sampled in IDLE only.
REQ-006 SHALL have port sf  input  4  per-cell sum-fault flags from the adder checker.
REQ-007 SHALL have port cf  input  4  per-cell carry-fault flags from the adder checker.
REQ-008 SHALL have port lut_o  output  3  test pattern index driven to the adder's pattern LUT.
REQ-009 SHALL have port test_en  output  1  adder in test mode; high in APPLY and SAMPLE.
REQ-010 SHALL have port cfg_sf  output  4  registered sum-fault map to the select generator.
REQ-011 SHALL have port cfg_cf  output  4  registered carry-fault map to the select generator.
REQ-012 SHALL have port cfg_valid  output  1  one-cycle pulse when cfg_sf/cfg_cf are updated.
REQ-013 SHALL have port done  output  1  level; last sweep complete.
REQ-014 SHALL have port uncorrectable  output  1  level; last sweep found more faulty cells than spares (1).

Function
REQ-015 SHALL implement states IDLE, APPLY, SAMPLE, EVAL, PUBLISH.
REQ-016 SHALL move IDLE->APPLY on start=1, clearing pattern index, acc_sf, acc_cf, done and uncorrectable in the same edge.
REQ-017 SHALL, in APPLY, drive lut_o=index and count SETTLE cycles, then enter SAMPLE.
REQ-018 SHALL, in SAMPLE (one cycle), OR sf into acc_sf and cf into acc_cf; flags outside SAMPLE SHALL be ignored.
REQ-019 SHALL go SAMPLE->APPLY with index+1 when index<7, SAMPLE->EVAL when index==7; index SHALL never wrap mid-sweep.
REQ-020 SHALL in EVAL compute faulty cells as acc_sf|acc_cf per bit and set uncorrectable when that popcount >1.
REQ-021 SHALL in PUBLISH load cfg_sf/cfg_cf from accumulators and pulse cfg_valid only when correctable; otherwise hold prior cfg maps and pulse nothing.
REQ-022 SHALL set done=1 on PUBLISH->IDLE; done and uncorrectable SHALL hold until the next sweep start.
REQ-023 SHALL complete a sweep in exactly 8*(SETTLE+1)+2 cycles from start edge to done rising.
REQ-024 SHALL ignore start while not in IDLE; no queued request.
REQ-025 SHALL hold lut_o at its last value and test_en=0 outside APPLY/SAMPLE.
REQ-026 SHALL treat zero faults as correctable: cfg maps become 0000, cfg_valid pulses.

Reset
REQ-027 SHALL on clr_n=0 immediately force state IDLE, lut_o=000, test_en=0, cfg_sf=0000, cfg_cf=0000, cfg_valid=0, done=0, uncorrectable=0, accumulators and counters 0.
REQ-028 SHALL abandon any sweep in progress on reset with no cfg update; operation resumes only on a new start or retest trigger.

Configuration
REQ-029 SHALL, with PERIODIC_RETEST_EN defined, count idle cycles after done and self-trigger a sweep when the count reaches RETEST_INTERVAL; counter resets on any sweep start.
REQ-030 SHALL, with PERIODIC_RETEST_EN defined, treat start and timer expiry on the same cycle as a single sweep.
REQ-031 SHALL, without PERIODIC_RETEST_EN, contain no interval counter and sweep only on start.

Verification
REQ-032 SHALL cover: SETTLE=2, sf=cf=0, start pulse -> lut_o steps 0..7, done after 26 cycles, cfg_valid pulse, cfg maps 0000.
REQ-033 SHALL cover: sf=0100 during SAMPLE of pattern 5 only -> cfg_sf=0100, cfg_cf=0000, uncorrectable=0.
REQ-034 SHALL cover: prior cfg_sf=0010, then sf=0001 and cf=1000 in one sweep -> uncorrectable=1, no cfg_valid, cfg_sf stays 0010.
REQ-035 SHALL cover: clr_n low during pattern 4 -> all outputs zero asynchronously, no cfg_valid, IDLE after release.
REQ-036 SHALL cover: start held high through a full sweep -> exactly one sweep per IDLE entry, second start ignored while busy.
REQ-037 SHALL cover (PERIODIC_RETEST_EN, RETEST_INTERVAL=16): no start after first done -> new sweep begins 16 idle cycles later.
